// File: rtl/rotate_mode_ctrl.sv
// Run-time rotation-mode controller: queues mode requests and applies them,
// together with a geometry snapshot, only at a camera frame boundary.
module rotate_mode_ctrl #(
  parameter int DEF_WIDTH   = 640,
  parameter int DEF_HIGH    = 480,
  parameter int MASK_FRAMES = 1
) (
  input  logic       cam_pclk,
  input  logic       rst_n,
  input  logic       cmos_frame_vsync,
  input  logic [1:0] mode_req,
  input  logic       mode_req_valid,
  output logic       mode_req_ready,
  input  logic       key_next,
  input  logic [9:0] img_width,
  input  logic [9:0] img_high,
  output logic [7:0] change_en,
  output logic [9:0] t_width,
  output logic [9:0] t_high,
  output logic [9:0] out_width,
  output logic [9:0] out_high,
  output logic [1:0] mode_cur,
  output logic       frame_mask,
  output logic       switch_done,
  output logic [1:0] fsm_state
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_PEND  = 2'd1,
    ST_APPLY = 2'd2,
    ST_MASK  = 2'd3
  } state_t;

  localparam logic [9:0] DEF_W  = DEF_WIDTH[9:0];
  localparam logic [9:0] DEF_H  = DEF_HIGH[9:0];
  localparam logic [2:0] MASK_N = MASK_FRAMES[2:0];

  function automatic logic [7:0] mode_code(input logic [1:0] m);
    logic [7:0] c;
    case (m)
      2'd0:    c = 8'h46;
      2'd1:    c = 8'h43;
      2'd2:    c = 8'h44;
      default: c = 8'h15;
    endcase
    return c;
  endfunction

  state_t     state;
  logic [1:0] pend_mode;
  logic [2:0] mask_cnt;
  logic       vs_d0;
  logic       vs_d1;
  logic       vs_pos;

  logic       accept_win;
  logic [1:0] base_mode;
  logic       req_any;
  logic [1:0] req_target;

  assign vs_pos    = vs_d0 & ~vs_d1;
  assign fsm_state = state;

  // Handshake: a request transfers on any rising cam_pclk edge where
  // mode_req_valid and mode_req_ready are both high; key_next is a one-cycle
  // pulse that behaves like a request for the next mode, but only when no
  // mode_req_valid is present in that cycle and the controller is ready.
  always_comb begin
    accept_win = 1'b0;
    base_mode  = mode_cur;
    req_any    = 1'b0;
    req_target = mode_cur;
    accept_win = (state == ST_RUN) || (state == ST_PEND);
    base_mode  = (state == ST_PEND) ? pend_mode : mode_cur;
    req_any    = accept_win & (mode_req_valid | key_next);
    req_target = mode_req_valid ? mode_req : base_mode + 2'd1;
  end

  always_ff @(posedge cam_pclk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_RUN;
      pend_mode      <= 2'd0;
      mask_cnt       <= 3'd0;
      vs_d0          <= 1'b0;
      vs_d1          <= 1'b0;
      mode_req_ready <= 1'b1;
      change_en      <= 8'h46;
      t_width        <= DEF_W;
      t_high         <= DEF_H;
      out_width      <= DEF_W;
      out_high       <= DEF_H;
      mode_cur       <= 2'd0;
      frame_mask     <= 1'b0;
      switch_done    <= 1'b0;
    end else begin
      vs_d0       <= cmos_frame_vsync;
      vs_d1       <= vs_d0;
      switch_done <= 1'b0;
      case (state)
        ST_RUN: begin
          // A vs_pos in this cycle is deliberately ignored: the request waits a frame.
          if (req_any && (req_target != mode_cur)) begin
            pend_mode <= req_target;
            state     <= ST_PEND;
          end
        end
        ST_PEND: begin
          if (req_any) begin
            pend_mode <= req_target;
            if (req_target == mode_cur) begin
              state <= ST_RUN;
            end else if (vs_pos) begin
              state          <= ST_APPLY;
              mode_req_ready <= 1'b0;
            end
          end else if (vs_pos) begin
            state          <= ST_APPLY;
            mode_req_ready <= 1'b0;
          end
        end
        ST_APPLY: begin
          change_en   <= mode_code(pend_mode);
          mode_cur    <= pend_mode;
          t_width     <= img_width;
          t_high      <= img_high;
          out_width   <= pend_mode[0] ? img_high : img_width;
          out_high    <= pend_mode[0] ? img_width : img_high;
          switch_done <= 1'b1;
          mask_cnt    <= MASK_N;
          if (MASK_N != 3'd0) begin
            state      <= ST_MASK;
            frame_mask <= 1'b1;
          end else begin
            state          <= ST_RUN;
            mode_req_ready <= 1'b1;
          end
        end
        ST_MASK: begin
          if (vs_pos) begin
            mask_cnt <= mask_cnt - 3'd1;
            if (mask_cnt <= 3'd1) begin
              frame_mask     <= 1'b0;
              mode_req_ready <= 1'b1;
              state          <= ST_RUN;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: doc/rotate_mode_ctrl.md
Name: rotate_mode_ctrl

Overview:
- Run-time controller for the image-rotation datapath on the camera pixel clock.
- Accepts rotation-mode requests from a host register port or a one-shot key pulse. Holds each request pending and applies it, with a snapshot of the image geometry, only at a frame boundary, so the rotation buffer never changes mode mid-frame.
- Drives the rotation datapath's mode code and geometry.
- Publishes the post-rotation geometry and a frame mask so the downstream writer discards the corrupted first frame(s) after each switch.

Parameters:
- DEF_WIDTH, 640: geometry width after reset, in pixels; legal range 8..1023.
- DEF_HIGH, 480: geometry height after reset, in lines; legal range 8..1023.
- MASK_FRAMES, 1: number of frames masked after an applied switch; legal range 0..7.

Ports:
- cam_pclk  in  1  pixel clock; all logic is on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmos_frame_vsync  in  1  camera vsync; active high during frame sync.
- mode_req  in  2  requested mode: 0 = no rotation, 1 = 90, 2 = 180, 3 = 270.
- mode_req_valid  in  1  request strobe; accepted when mode_req_ready is high.
- mode_req_ready  out  1  controller can accept a request.
- key_next  in  1  single-cycle pulse, already synchronised and debounced: step to the next mode (0→1→2→3→0).
- img_width  in  10  source width; sampled only when a switch is applied.
- img_high  in  10  source height; sampled only when a switch is applied.
- change_en  out  8  datapath mode code: 0x46 none, 0x43 90, 0x44 180, 0x15 270.
- t_width  out  10  latched source width fed to the datapath.
- t_high  out  10  latched source height fed to the datapath.
- out_width  out  10  post-rotation width (t_high for 90/270, else t_width).
- out_high  out  10  post-rotation height (t_width for 90/270, else t_high).
- mode_cur  out  2  currently applied mode.
- frame_mask  out  1  high while downstream must drop frames.
- switch_done  out  1  one-cycle pulse when a switch is applied.

Behaviour:
- Reset values:
  - change_en = 0x46, mode_cur = 0.
  - t_width = DEF_WIDTH, t_high = DEF_HIGH; out_width/out_high follow the same rule as run time (so 640/480 at default).
  - frame_mask = 0, switch_done = 0, mode_req_ready = 1, state RUN, no pending request.
- vsync handling:
  - Two-stage register vs_d0, vs_d1.
  - Rising edge vs_pos = vs_d0 & ~vs_d1.
  - Mode is applied on vs_pos, so it is stable before the datapath's vsync falling-edge address reset.
- States:
  - RUN: ready = 1. An accepted request whose mode differs from mode_cur latches pend_mode and moves to PEND. A request equal to mode_cur is discarded with no state change and no pulse.
  - PEND: ready = 1. A new accepted request overwrites pend_mode; if the new mode equals mode_cur, the pending switch is cancelled and the state returns to RUN. On vs_pos, go to APPLY.
  - APPLY (one cycle):
    - Registered outputs update on the APPLY→next edge: change_en, mode_cur, t_width ← img_width, t_high ← img_high, out_width/out_high.
    - Pulse switch_done.
    - Load mask_cnt = MASK_FRAMES.
    - Next state is MASK if MASK_FRAMES > 0, else RUN.
  - MASK: ready = 0, frame_mask = 1. Each vs_pos decrements mask_cnt; on the vs_pos where mask_cnt == 1, clear frame_mask and return to RUN. Requests are not accepted; key_next pulses are dropped.
- Request sources:
  - key_next target is (pend_mode + 1) mod 4 in PEND, else (mode_cur + 1) mod 4.
  - When mode_req_valid and key_next arrive in the same cycle, mode_req_valid wins and key_next is dropped.
- Timing and geometry rules:
  - A vs_pos in the same cycle as an accepted request in RUN does not apply it; the request waits for the next vs_pos.
  - A vs_pos in the same cycle as an overwriting request in PEND applies the new pend_mode.
  - Geometry is only latched in APPLY; img_width/img_high changes at any other time are ignored.
  - out_width/out_high are a pure function of the registered mode and geometry, registered in the same cycle, so there is no skew against change_en.
- Any rst_n assertion, including mid-PEND or mid-MASK, returns everything to reset values immediately; the pending request is lost.

Test Plan:
- Reset, then vsync pulses with no request → change_en stays 0x46, t_width = 640, t_high = 480, frame_mask = 0, no switch_done.
- mode_req = 1 strobed mid-frame with img_width = 320, img_high = 240 → no change until the next vsync rise; 2 cycles after vs_d0 rises, change_en = 0x43, t_width = 320, t_high = 240, out_width = 240, out_high = 320, switch_done pulses once, frame_mask high for exactly 1 frame, ready = 0 during that frame.
- In PEND with pending 180, request 270 then 0 while mode_cur = 0 → pending cancelled, state returns to RUN; next vsync produces no switch_done and change_en stays 0x46.
- From mode 3, four key_next pulses spread across frames (each after the mask clears) → change_en sequence 0x46, 0x43, 0x44, 0x15. Also: key_next and mode_req_valid (mode 2) in the same cycle → result 0x44.
- MASK_FRAMES = 3: switch to 180 → frame_mask high across 3 vsync rises; a key_next during MASK is ignored.
- rst_n low during MASK → frame_mask = 0, change_en = 0x46 and mode_req_ready = 1 asynchronously, before the next clock edge.
